// File: rtl/ec_point_add_seq.sv
// Sequential affine point adder/doubler over GF(P) for y^2 = x^3 + CURVE_A*x + b.
// Slope, x3 and y3 each get their own registered cycle so no modular multiply feeds a divide in one cycle.
module ec_point_add_seq #(
  parameter int                   DATAWIDTH = 5,
  parameter logic [DATAWIDTH-1:0] P         = DATAWIDTH'(17),
  parameter logic [DATAWIDTH-1:0] CURVE_A   = DATAWIDTH'(0)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] x1,
  input  logic [DATAWIDTH-1:0] y1,
  input  logic                 inf1,
  input  logic [DATAWIDTH-1:0] x2,
  input  logic [DATAWIDTH-1:0] y2,
  input  logic                 inf2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] x3,
  output logic [DATAWIDTH-1:0] y3,
  output logic                 inf3
);

  localparam int DW = DATAWIDTH;
  localparam logic [DW-1:0] INV_EXP = P - DW'(2);

  typedef enum logic [2:0] {IDLE, CLASSIFY, LAMBDA, X3, Y3, DONE} state_e;

  function automatic logic [DW-1:0] modAdd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] modSub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a >= b) ? (a - b) : (a + (P - b));
  endfunction

  function automatic logic [DW-1:0] modMul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] prod;
    prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    prod = prod % {{DW{1'b0}}, P};
    return prod[DW-1:0];
  endfunction

  // Inverse by Fermat: b^(P-2), square-and-multiply over the constant exponent bits.
  function automatic logic [DW-1:0] modInv(input logic [DW-1:0] b);
    logic [DW-1:0] acc;
    logic [DW-1:0] base;
    acc  = DW'(1);
    base = b;
    for (int i = 0; i < DW; i++) begin
      if (INV_EXP[i]) acc = modMul(acc, base);
      base = modMul(base, base);
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] modDiv(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return modMul(a, modInv(b));
  endfunction

  state_e        state_q, state_d;
  logic [DW-1:0] x1_q, y1_q, x2_q, y2_q;
  logic [DW-1:0] x1_d, y1_d, x2_d, y2_d;
  logic          inf1_q, inf2_q, inf1_d, inf2_d;
  logic          dbl_q, dbl_d;
  logic [DW-1:0] tsq_q, tsq_d;
  logic [DW-1:0] lam_q, lam_d;
  logic [DW-1:0] xr_q, xr_d;
  logic [DW-1:0] x3_q, y3_q, x3_d, y3_d;
  logic          inf3_q, inf3_d;
  logic          out_valid_q, out_valid_d;

  logic [DW-1:0] negY2;
  logic [DW-1:0] threeT;
  logic [DW-1:0] numDbl, denDbl, numAdd, denAdd;

  always_comb begin
    negY2  = (y2_q == '0) ? '0 : (P - y2_q);
    threeT = modAdd(tsq_q, modAdd(tsq_q, tsq_q));
    numDbl = modAdd(threeT, CURVE_A);
    denDbl = modAdd(y1_q, y1_q);
    numAdd = modSub(y2_q, y1_q);
    denAdd = modSub(x2_q, x1_q);
  end

  always_comb begin
    state_d     = state_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    inf1_d      = inf1_q;
    x2_d        = x2_q;
    y2_d        = y2_q;
    inf2_d      = inf2_q;
    dbl_d       = dbl_q;
    tsq_d       = tsq_q;
    lam_d       = lam_q;
    xr_d        = xr_q;
    x3_d        = x3_q;
    y3_d        = y3_q;
    inf3_d      = inf3_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x1_d    = x1;
          y1_d    = y1;
          inf1_d  = inf1;
          x2_d    = x2;
          y2_d    = y2;
          inf2_d  = inf2;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        // x1^2 is registered here so the slope cycle only has to divide.
        tsq_d = modMul(x1_q, x1_q);
        if (inf1_q) begin
          x3_d        = inf2_q ? '0 : x2_q;
          y3_d        = inf2_q ? '0 : y2_q;
          inf3_d      = inf2_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (inf2_q) begin
          x3_d        = x1_q;
          y3_d        = y1_q;
          inf3_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if ((x1_q == x2_q) && (y1_q == negY2)) begin
          x3_d        = '0;
          y3_d        = '0;
          inf3_d      = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          dbl_d   = (x1_q == x2_q) && (y1_q == y2_q);
          state_d = LAMBDA;
        end
      end
      LAMBDA: begin
        lam_d   = dbl_q ? modDiv(numDbl, denDbl) : modDiv(numAdd, denAdd);
        state_d = X3;
      end
      X3: begin
        xr_d    = modSub(modSub(modMul(lam_q, lam_q), x1_q), x2_q);
        state_d = Y3;
      end
      Y3: begin
        x3_d        = xr_q;
        y3_d        = modSub(modMul(lam_q, modSub(x1_q, xr_q)), y1_q);
        inf3_d      = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x1_q        <= '0;
      y1_q        <= '0;
      inf1_q      <= 1'b0;
      x2_q        <= '0;
      y2_q        <= '0;
      inf2_q      <= 1'b0;
      dbl_q       <= 1'b0;
      tsq_q       <= '0;
      lam_q       <= '0;
      xr_q        <= '0;
      x3_q        <= '0;
      y3_q        <= '0;
      inf3_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      inf1_q      <= inf1_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      inf2_q      <= inf2_d;
      dbl_q       <= dbl_d;
      tsq_q       <= tsq_d;
      lam_q       <= lam_d;
      xr_q        <= xr_d;
      x3_q        <= x3_d;
      y3_q        <= y3_d;
      inf3_q      <= inf3_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign x3        = x3_q;
  assign y3        = y3_q;
  assign inf3      = inf3_q;

endmodule

// File: tb/tb_ec_point_add_seq.sv
// Scoreboard bench for ec_point_add_seq on y^2 = x^3 + 2x + 2 over GF(17).
// Expected points below were worked by hand with the affine add/double formulas.
module tb_ec_point_add_seq;

  localparam int DW = 5;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          inf;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x1, y1, x2, y2;
  logic          inf1, inf2;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] x3, y3;
  logic          inf3;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;
  int   cycleCnt = 0;

  ec_point_add_seq #(
    .DATAWIDTH(DW),
    .P        (5'd17),
    .CURVE_A  (5'd2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x1       (x1),
    .y1       (y1),
    .inf1     (inf1),
    .x2       (x2),
    .y2       (y2),
    .inf2     (inf2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x3       (x3),
    .y3       (y3),
    .inf3     (inf3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Latency is the index of the first edge that sees out_valid, with the accept edge as 0.
  task automatic monitor();
    int   acceptEdge = 0;
    logic prevValid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 1'b0;
        continue;
      end
      if (in_valid && in_ready) acceptEdge = cycleCnt + 1;
      if (out_valid && !prevValid) begin
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_out_valid: got x3=%0d y3=%0d inf3=%0d, expected no result", x3, y3, inf3);
        end else if ((cycleCnt + 1 - acceptEdge) != expQ[0].lat) begin
          fails++;
          $display("[TB] FAIL latency: got %0d, expected %0d", cycleCnt + 1 - acceptEdge, expQ[0].lat);
        end
      end
      if (out_valid && out_ready && expQ.size() != 0) begin
        e = expQ.pop_front();
        tests++;
        if (x3 !== e.x || y3 !== e.y || inf3 !== e.inf) begin
          fails++;
          $display("[TB] FAIL result: got (%0d,%0d,inf=%0d), expected (%0d,%0d,inf=%0d)",
                   x3, y3, inf3, e.x, e.y, e.inf);
        end
      end
      prevValid = out_valid;
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] ax1, input logic [DW-1:0] ay1, input logic ai1,
                               input logic [DW-1:0] ax2, input logic [DW-1:0] ay2, input logic ai2,
                               input logic [DW-1:0] ex, input logic [DW-1:0] ey, input logic ei,
                               input int el, input bit expectResult);
    int   guard = 0;
    exp_t e;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL ready_timeout: got in_ready=0, expected 1");
      return;
    end
    x1 = ax1; y1 = ay1; inf1 = ai1;
    x2 = ax2; y2 = ay2; inf2 = ai2;
    in_valid = 1'b1;
    if (expectResult) begin
      e.x = ex; e.y = ey; e.inf = ei; e.lat = el;
      expQ.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    if (expQ.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    int sawValid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x1 = '0; y1 = '0; inf1 = 1'b0; x2 = '0; y2 = '0; inf2 = 1'b0;
    fork monitor(); join_none

    #12;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_outputs", int'({x3, y3, inf3}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Additions, doublings, then the one-cycle special cases.
    applyStimulus(5, 1, 0, 6, 3, 0, 10, 6, 0, 5, 1);
    applyStimulus(3, 1, 0, 5, 1, 0, 9, 16, 0, 5, 1);
    applyStimulus(5, 1, 0, 5, 1, 0, 6, 3, 0, 5, 1);
    applyStimulus(6, 3, 0, 6, 3, 0, 3, 1, 0, 5, 1);
    applyStimulus(0, 6, 0, 0, 6, 0, 9, 1, 0, 5, 1);
    applyStimulus(5, 1, 0, 5, 16, 0, 0, 0, 1, 2, 1);
    applyStimulus(7, 9, 1, 10, 6, 0, 10, 6, 0, 2, 1);
    applyStimulus(7, 9, 1, 4, 4, 1, 0, 0, 1, 2, 1);
    applyStimulus(3, 1, 0, 8, 8, 1, 3, 1, 0, 2, 1);
    waitDrain();

    // Back-pressure: result must hold and new requests must be dropped.
    out_ready = 1'b0;
    applyStimulus(5, 1, 0, 6, 3, 0, 10, 6, 0, 5, 1);
    sawValid = 0;
    while (!out_valid && sawValid < 20) begin
      @(posedge clk); #1;
      sawValid++;
    end
    for (int i = 0; i < 10; i++) begin
      x1 = 5'd3; y1 = 5'd1; inf1 = 1'b1; x2 = 5'd5; y2 = 5'd1; inf2 = 1'b0;
      in_valid = 1'b1;
      checkOutput("hold_state", int'({out_valid, in_ready, x3, y3, inf3}),
                  int'({1'b1, 1'b0, 5'd10, 5'd6, 1'b0}));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_out_valid", int'(out_valid), 0);
    checkOutput("release_in_ready", int'(in_ready), 1);
    waitDrain();
    repeat (6) @(posedge clk);
    #1;

    // Abort in the X3 state: reset clears everything and no result appears.
    applyStimulus(5, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", int'(in_ready), 1);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_outputs", int'({x3, y3, inf3}), 0);
    #2;
    rst_n = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid++;
    end
    checkOutput("abort_no_result", sawValid, 0);

    applyStimulus(5, 1, 0, 5, 1, 0, 6, 3, 0, 5, 1);
    waitDrain();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
